// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO types and width helpers
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // One extra pointer bit acts as the wrap flag that separates full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int lvl_width(input int capacity);
        return $clog2(capacity + 1);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_out_stage.sv
// rtl/fifo_out_stage.sv - registered head entry with write bypass for empty memory
module fifo_out_stage #(
    parameter int DataWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 clear_i,
    input  logic                 rready_i,
    input  logic                 mem_valid_i,
    input  logic [DataWidth-1:0] mem_data_i,
    input  logic                 wr_fire_i,
    input  logic [DataWidth-1:0] wr_data_i,
    output logic                 mem_pop_o,
    output logic                 bypass_o,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] data_o
);

    logic                 valid_q, valid_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 free;

    assign free = !valid_q || rready_i;

    // Memory entries are older than the incoming word, so they win the reload.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        mem_pop_o = 1'b0;
        bypass_o  = 1'b0;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (free) begin
            if (mem_valid_i) begin
                valid_d   = 1'b1;
                data_d    = mem_data_i;
                mem_pop_o = 1'b1;
            end else if (wr_fire_i) begin
                valid_d  = 1'b1;
                data_d   = wr_data_i;
                bypass_o = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign rvalid_o = valid_q;
    assign data_o   = data_q;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// rtl/fifo_sync_ctrl.sv - single-clock FIFO with level, thresholds, flush; FIFO_OVERFLOW_DETECT_EN adds overflow_o
module fifo_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int DataWidth      = 8,
    parameter int Depth          = 16,
    parameter int AlmostFullThr  = 12,
    parameter int AlmostEmptyThr = 2,
    parameter int OutReg         = 0,
    localparam int Capacity      = Depth + OutReg,
    localparam int LvlW          = lvl_width(Capacity)
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 clear_i,
    input  logic                 wvalid_i,
    output logic                 wready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic [DataWidth-1:0] data_o,
    output logic [LvlW-1:0]      level_o,
    output logic                 is_full_o,
    output logic                 is_empty_o,
    output logic                 almost_full_o,
`ifdef FIFO_OVERFLOW_DETECT_EN
    output logic                 overflow_o,
`endif
    output logic                 almost_empty_o
);

    localparam int AW = $clog2(Depth);
    localparam int PW = ptr_width(Depth);

    if (!is_pow2(Depth)) begin : g_err_depth
        $error("fifo_sync_ctrl: Depth must be a power of two >= 2");
    end
    if (AlmostFullThr < 1 || AlmostFullThr > Capacity) begin : g_err_afull
        $error("fifo_sync_ctrl: AlmostFullThr outside 1..Capacity");
    end
    if (AlmostEmptyThr < 0 || AlmostEmptyThr > Capacity - 1) begin : g_err_aempty
        $error("fifo_sync_ctrl: AlmostEmptyThr outside 0..Capacity-1");
    end

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 ready_q, ready_d;
    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] mem_rd_data;
    logic [PW-1:0]        mem_level;
    logic                 mem_empty, mem_full;
    logic                 mem_push, mem_pop;
    logic                 wr_fire, head_valid;
    logic                 full_w, empty_w;
    fifo_status_t         status;

    assign mem_level   = wr_ptr_q - rd_ptr_q;
    assign mem_empty   = (wr_ptr_q == rd_ptr_q);
    assign mem_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign mem_rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // ready_q keeps wready_o low until the first edge after reset release.
    assign wready_o = ready_q && !status.full;
    assign wr_fire  = wvalid_i && wready_o && !clear_i;

    if (OutReg != 0) begin : g_out_reg
        logic out_valid;
        logic bypass;

        fifo_out_stage #(
            .DataWidth (DataWidth)
        ) u_out_stage (
            .clk_i       (clk_i),
            .reset_ni    (reset_ni),
            .clear_i     (clear_i),
            .rready_i    (rready_i),
            .mem_valid_i (!mem_empty),
            .mem_data_i  (mem_rd_data),
            .wr_fire_i   (wr_fire),
            .wr_data_i   (data_i),
            .mem_pop_o   (mem_pop),
            .bypass_o    (bypass),
            .rvalid_o    (out_valid),
            .data_o      (data_o)
        );

        assign mem_push   = wr_fire && !bypass;
        assign head_valid = out_valid;
        assign full_w     = mem_full && out_valid;
        assign empty_w    = !out_valid;
        assign level_o    = LvlW'(mem_level) + LvlW'(out_valid);
    end else begin : g_comb_head
        assign head_valid = !mem_empty;
        assign mem_push   = wr_fire;
        assign mem_pop    = head_valid && rready_i && !clear_i;
        assign full_w     = mem_full;
        assign empty_w    = mem_empty;
        assign level_o    = LvlW'(mem_level);
        // Stale memory is masked so an empty FIFO presents zero.
        assign data_o     = mem_empty ? '0 : mem_rd_data;
    end

    always_comb begin
        status              = '0;
        status.full         = full_w;
        status.empty        = empty_w;
        status.almost_full  = (level_o >= LvlW'(AlmostFullThr));
        status.almost_empty = (level_o <= LvlW'(AlmostEmptyThr));
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ready_d  = 1'b1;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (mem_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (mem_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    assign rvalid_o       = head_valid;
    assign is_full_o      = status.full;
    assign is_empty_o     = status.empty;
    assign almost_full_o  = status.almost_full;
    assign almost_empty_o = status.almost_empty;

`ifdef FIFO_OVERFLOW_DETECT_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (clear_i)                     overflow_d = 1'b0;
        else if (wvalid_i && !wready_o)  overflow_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) overflow_q <= 1'b0;
        else           overflow_q <= overflow_d;
    end

    assign overflow_o = overflow_q;

    always_ff @(posedge clk_i) begin
        if (reset_ni) assert (int'(level_o) <= Capacity);
    end
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb/tb_fifo_sync_ctrl.sv - directed checks of fifo_sync_ctrl with OutReg=0 and OutReg=1
module tb_fifo_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr0, wv0, rr0, wr0, rv0, full0, empty0, af0, ae0;
    logic [7:0] din0, do0;
    logic [4:0] lvl0;
    logic       clr1, wv1, rr1, wr1, rv1, full1, empty1, af1, ae1;
    logic [7:0] din1, do1;
    logic [4:0] lvl1;
`ifdef FIFO_OVERFLOW_DETECT_EN
    logic       ov0, ov1;
`endif
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_sync_ctrl #(.DataWidth(8), .Depth(16), .AlmostFullThr(12), .AlmostEmptyThr(2), .OutReg(0)) u_dut0 (
        .clk_i(clk), .reset_ni(rst_n), .clear_i(clr0), .wvalid_i(wv0), .wready_o(wr0),
        .data_i(din0), .rvalid_o(rv0), .rready_i(rr0), .data_o(do0), .level_o(lvl0),
        .is_full_o(full0), .is_empty_o(empty0), .almost_full_o(af0),
`ifdef FIFO_OVERFLOW_DETECT_EN
        .overflow_o(ov0),
`endif
        .almost_empty_o(ae0)
    );

    fifo_sync_ctrl #(.DataWidth(8), .Depth(16), .AlmostFullThr(12), .AlmostEmptyThr(2), .OutReg(1)) u_dut1 (
        .clk_i(clk), .reset_ni(rst_n), .clear_i(clr1), .wvalid_i(wv1), .wready_o(wr1),
        .data_i(din1), .rvalid_o(rv1), .rready_i(rr1), .data_o(do1), .level_o(lvl1),
        .is_full_o(full1), .is_empty_o(empty1), .almost_full_o(af1),
`ifdef FIFO_OVERFLOW_DETECT_EN
        .overflow_o(ov1),
`endif
        .almost_empty_o(ae1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {clr0, wv0, rr0, clr1, wv1, rr1} = '0;
        din0 = '0;
        din1 = '0;
        #12;
        chk("rst_wready_low", wr0, 0);
        chk("rst_level", lvl0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_rvalid", rv0, 0);
        chk("rst_aempty", ae0, 1);
        chk("rst_afull", af0, 0);
        chk("rst_data0", do0, 0);
        chk("rst_data1", do1, 0);
        chk("rst_rvalid1", rv1, 0);
        rst_n = 1'b1;
        tick();
        chk("wready_after_release", wr0, 1);
        chk("wready1_after_release", wr1, 1);

        for (int i = 0; i < 3; i++) begin
            wv0 = 1'b1; din0 = 8'h30 + 8'(i); tick();
        end
        wv0 = 1'b0;
        chk("pre_reset_level", lvl0, 3);
        chk("pre_reset_head", do0, 8'h30);
        #2; rst_n = 1'b0; #1;
        chk("async_rst_level", lvl0, 0);
        chk("async_rst_rvalid", rv0, 0);
        chk("async_rst_wready", wr0, 0);
        chk("async_rst_empty", empty0, 1);
        chk("async_rst_data", do0, 0);
        #1; rst_n = 1'b1;
        tick();
        chk("rerelease_wready", wr0, 1);
        chk("rerelease_level", lvl0, 0);

        for (int i = 0; i < 16; i++) begin
            wv0 = 1'b1; din0 = 8'(i); tick();
            if (i == 1)  chk("aempty_at_2", ae0, 1);
            if (i == 2)  chk("aempty_at_3", ae0, 0);
            if (i == 10) chk("afull_at_11", af0, 0);
            if (i == 11) chk("afull_at_12", af0, 1);
        end
        wv0 = 1'b0;
        chk("fill_full", full0, 1);
        chk("fill_level", lvl0, 16);
        chk("fill_wready", wr0, 0);
        wv0 = 1'b1; din0 = 8'hEE; tick(); wv0 = 1'b0;
        chk("refused_level", lvl0, 16);
        chk("refused_head", do0, 8'h00);
`ifdef FIFO_OVERFLOW_DETECT_EN
        chk("overflow0_set", ov0, 1);
`endif
        rr0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("fill_read_order", do0, i); tick();
        end
        rr0 = 1'b0;
        chk("half_level", lvl0, 8);
        for (int i = 0; i < 8; i++) begin
            wv0 = 1'b1; din0 = 8'h10 + 8'(i); tick();
        end
        wv0 = 1'b0;
        chk("wrap_full", full0, 1);
        rr0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("wrap_order", do0, 8 + i); tick();
        end
        rr0 = 1'b0;
        chk("drain_empty", empty0, 1);
        chk("drain_level", lvl0, 0);
        chk("drain_rvalid", rv0, 0);

        for (int i = 0; i < 5; i++) begin
            wv0 = 1'b1; din0 = 8'h20 + 8'(i); tick();
        end
        rr0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din0 = 8'h25 + 8'(i);
            chk("simul_order", do0, 8'h20 + i);
            tick();
            chk("simul_level", lvl0, 5);
        end
        wv0 = 1'b0; rr0 = 1'b0;
        chk("simul_head", do0, 8'h34);
        for (int i = 0; i < 11; i++) begin
            wv0 = 1'b1; din0 = 8'h39 + 8'(i); tick();
        end
        chk("simul_full", full0, 1);
        din0 = 8'h50; rr0 = 1'b1; tick();
        chk("full_simul_level", lvl0, 15);
        chk("full_simul_wready", wr0, 1);
        rr0 = 1'b0; tick(); wv0 = 1'b0;
        chk("full_recover_level", lvl0, 16);
        rr0 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            chk("full_simul_order", do0, 8'h35 + i); tick();
        end
        chk("full_simul_last", do0, 8'h50); tick();
        rr0 = 1'b0;
        chk("full_simul_empty", empty0, 1);

        wv0 = 1'b1; rr0 = 1'b1; din0 = 8'h60; tick();
        chk("empty_simul_level", lvl0, 1);
        chk("empty_simul_data", do0, 8'h60);
        wv0 = 1'b0; tick(); rr0 = 1'b0;
        chk("empty_simul_drain", lvl0, 0);

        wv0 = 1'b1; din0 = 8'h70; tick(); din0 = 8'h71; tick();
        din0 = 8'h72; rr0 = 1'b1; clr0 = 1'b1; tick();
        clr0 = 1'b0; wv0 = 1'b0; rr0 = 1'b0;
        chk("clear0_level", lvl0, 0);
        chk("clear0_empty", empty0, 1);
        chk("clear0_wready", wr0, 1);
        chk("clear0_data", do0, 0);
`ifdef FIFO_OVERFLOW_DETECT_EN
        chk("clear0_overflow", ov0, 0);
`endif

        wv1 = 1'b1; din1 = 8'hA5; tick(); wv1 = 1'b0;
        chk("bypass_rvalid", rv1, 1);
        chk("bypass_data", do1, 8'hA5);
        chk("bypass_level", lvl1, 1);
        for (int i = 0; i < 10; i++) begin
            if (i < 3) begin
                wv1 = 1'b1; din1 = 8'hB0 + 8'(i);
            end else begin
                wv1 = 1'b0;
            end
            tick();
            chk("hold_stable", do1, 8'hA5);
        end
        chk("hold_level", lvl1, 4);
        rr1 = 1'b1;
        chk("outreg_order0", do1, 8'hA5); tick();
        for (int i = 0; i < 3; i++) begin
            chk("outreg_order", do1, 8'hB0 + i); tick();
        end
        rr1 = 1'b0;
        chk("outreg_drained", rv1, 0);
        chk("outreg_level0", lvl1, 0);
        wv1 = 1'b1; din1 = 8'hC0; tick();
        din1 = 8'hC1; rr1 = 1'b1; tick();
        wv1 = 1'b0; rr1 = 1'b0;
        chk("bypass_under_read", do1, 8'hC1);
        chk("bypass_under_read_lvl", lvl1, 1);
        rr1 = 1'b1; tick(); rr1 = 1'b0;
        chk("bypass_drained", rv1, 0);

        for (int i = 0; i < 17; i++) begin
            wv1 = 1'b1; din1 = 8'(i); tick();
        end
        wv1 = 1'b0;
        chk("cap17_level", lvl1, 17);
        chk("cap17_full", full1, 1);
        chk("cap17_wready", wr1, 0);
        chk("cap17_afull", af1, 1);
        chk("cap17_head", do1, 0);
        wv1 = 1'b1; din1 = 8'hFF; tick(); wv1 = 1'b0;
        chk("cap17_refused", lvl1, 17);
`ifdef FIFO_OVERFLOW_DETECT_EN
        chk("overflow1_set", ov1, 1);
`endif
        clr1 = 1'b1; rr1 = 1'b1; tick();
        clr1 = 1'b0; rr1 = 1'b0;
        chk("clear1_level", lvl1, 0);
        chk("clear1_rvalid", rv1, 0);
        chk("clear1_empty", empty1, 1);
        chk("clear1_data", do1, 0);
        chk("clear1_aempty", ae1, 1);
`ifdef FIFO_OVERFLOW_DETECT_EN
        chk("clear1_overflow", ov1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
